// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   INST_W           : instruction / address width
//   PC_INC           : byte increment between sequential fetches
//   DEFAULT_RESET_PC : default address of the first fetch after reset
//   FIFO_W           : width of one buffer entry ({inst, pc})
//   fetch_state_e    : fetch FSM states
package instr_fetch_pkg;

  localparam int unsigned INST_W           = 32;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;
  localparam int unsigned FIFO_W           = 2 * INST_W;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: a small synchronous FIFO with flush.
//   clk, rst     : clock, synchronous active-high reset
//   push, wdata  : write wdata at the tail (accepted when not full, or full with pop)
//   pop          : drop the head entry (ignored when empty)
//   flush        : discard all entries; overrides push and pop
//   rdata        : head entry, '0 while empty
//   full, empty  : occupancy flags
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop, mem_we;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_we   = do_push && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by plain overflow.
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: rdata is masked while empty.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks a PC through a combinational ROM and queues
// {instruction, pc} pairs for a valid/ready consumer.
//   clk, rst                    : clock, synchronous active-high reset
//   run                         : fetch enable (STOP/RUN FSM)
//   rom_addr / rom_data         : combinational ROM address / word
//   redirect_valid/redirect_pc  : one-cycle branch/jump; flushes and reloads pc
//   inst, inst_pc, inst_valid   : head of the instruction buffer
//   inst_ready                  : consumer accepts the head when valid&ready
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetch_state_e      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              fifo_full, fifo_empty;
  logic              fetch, pop;
  logic [FIFO_W-1:0] fifo_rdata;

  assign rom_addr   = pc_q;
  assign inst_valid = !fifo_empty;
  assign inst       = fifo_rdata[FIFO_W-1:INST_W];
  assign inst_pc    = fifo_rdata[INST_W-1:0];

  always_comb begin
    // A redirect flushes the buffer, so it also suppresses pop and fetch.
    pop     = inst_valid && inst_ready && !redirect_valid;
    fetch   = (state_q == ST_RUN) && !redirect_valid && (!fifo_full || pop);
    state_d = run ? ST_RUN : ST_STOP;
    pc_d    = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (fetch) begin
      pc_d = pc_q + PC_INC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_STOP;
      pc_q    <= RESET_PC_ALIGNED;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fetch),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({rom_data, pc_q}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
